// File: rtl/dmem_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_lsu_if
//  Purpose  : Bundles the pipeline request/response handshake and the
//             word-only data-memory bus of the load/store unit.
//  Ports    : req_*  - pipeline request (valid/ready handshake)
//             resp_* - one-cycle completion pulse with data/fault
//             mem_*  - word-aligned memory cycle, mem_rd combinational
//  Modports : slave  - the load/store unit itself
//             master - the environment (pipeline MEM stage + data memory)
//  Revision : 1.0  initial release
// ============================================================================
interface dmem_lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;

   logic        mem_we;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      input  mem_rd,
      output req_ready, resp_valid, resp_rdata, resp_fault,
      output mem_we, mem_a, mem_wd
   );

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      output mem_rd,
      input  req_ready, resp_valid, resp_rdata, resp_fault,
      input  mem_we, mem_a, mem_wd
   );
endinterface
`default_nettype wire

// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_lsu
//  Purpose  : Load/store initiator between the pipeline MEM stage and a
//             word-only data memory. Byte/half/word requests become
//             word-aligned memory cycles; sub-word stores use
//             read-modify-write; loads are lane-extracted and sign- or
//             zero-extended. Misaligned, illegal-size and out-of-range
//             accesses are faulted without touching memory.
//  Ports    : clk   - system clock, rising edge
//             reset - asynchronous, active-high reset
//             bus   - dmem_lsu_if.slave (request, response, memory bus)
//  Params   : MEM_WORDS - number of 32-bit words backed by memory
//  Revision : 1.0  initial release
// ============================================================================
module dmem_lsu #(
   parameter int MEM_WORDS = 512
) (
   input  wire logic   clk,
   input  wire logic   reset,
   dmem_lsu_if.slave   bus
);

   // Word-index limit at the width of addr[31:2].
   localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nx;

   // Request captured at acceptance; the pipeline inputs are don't-care
   // once the handshake completes.
   logic        we_q;
   logic [1:0]  size_q;
   logic        signed_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        fault_q;

   // Memory word captured during RD, used both for RMW merge and loads.
   logic [31:0] word_q;

   logic        accept;
   logic        fault_c;
   logic [31:0] merged;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] load_data;

   assign accept = (state == S_IDLE) && bus.req_valid;

   // -------------------------------------------------------------------------
   // Fault classification of the incoming request
   // -------------------------------------------------------------------------
   always_comb begin
      fault_c = 1'b0;
      case (bus.req_size)
         SZ_BYTE: fault_c = 1'b0;
         SZ_HALF: fault_c = bus.req_addr[0];
         SZ_WORD: fault_c = |bus.req_addr[1:0];
         default: fault_c = 1'b1;
      endcase
      if (bus.req_addr[31:2] >= WORD_LIMIT) begin
         fault_c = 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (bus.req_valid) begin
               if (fault_c) begin
                  state_nx = S_RESP;
               end else if (!bus.req_we) begin
                  state_nx = S_RD;
               end else if (bus.req_size == SZ_WORD) begin
                  state_nx = S_WR;
               end else begin
                  // Sub-word store: fetch the word first for the merge.
                  state_nx = S_RD;
               end
            end
         end
         S_RD:    state_nx = we_q ? S_WR : S_RESP;
         S_WR:    state_nx = S_RESP;
         S_RESP:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Request latch
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_q     <= 1'b0;
         size_q   <= 2'b00;
         signed_q <= 1'b0;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         fault_q  <= 1'b0;
      end else if (accept) begin
         we_q     <= bus.req_we;
         size_q   <= bus.req_size;
         signed_q <= bus.req_signed;
         addr_q   <= bus.req_addr;
         wdata_q  <= bus.req_wdata;
         fault_q  <= fault_c;
      end
   end

   // -------------------------------------------------------------------------
   // Read-word capture
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word_q <= 32'h0;
      end else if (state == S_RD) begin
         word_q <= bus.mem_rd;
      end
   end

   // -------------------------------------------------------------------------
   // Store merge: replace the addressed little-endian lane(s) of word_q.
   // Word stores bypass the merge and write wdata directly.
   // -------------------------------------------------------------------------
   always_comb begin
      merged = word_q;
      case (size_q)
         SZ_BYTE: merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
         SZ_HALF: merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
         default: merged = wdata_q;
      endcase
   end

   // -------------------------------------------------------------------------
   // Load extraction and extension
   // -------------------------------------------------------------------------
   assign lane_b = word_q[{addr_q[1:0], 3'b000} +: 8];
   assign lane_h = word_q[{addr_q[1], 4'b0000} +: 16];

   always_comb begin
      load_data = word_q;
      case (size_q)
         SZ_BYTE: load_data = {{24{signed_q & lane_b[7]}}, lane_b};
         SZ_HALF: load_data = {{16{signed_q & lane_h[15]}}, lane_h};
         default: load_data = word_q;
      endcase
   end

   // -------------------------------------------------------------------------
   // Outputs: decoded from state and latched request only, so an
   // asynchronous reset removes mem_we and any response at once.
   // -------------------------------------------------------------------------
   always_comb begin
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_fault = 1'b0;
      bus.resp_rdata = 32'h0;
      bus.mem_we     = 1'b0;
      bus.mem_a      = 32'h0;
      bus.mem_wd     = 32'h0;
      case (state)
         S_IDLE: begin
            bus.req_ready = 1'b1;
         end
         S_RD: begin
            bus.mem_a = {addr_q[31:2], 2'b00};
         end
         S_WR: begin
            bus.mem_we = 1'b1;
            bus.mem_a  = {addr_q[31:2], 2'b00};
            bus.mem_wd = merged;
         end
         S_RESP: begin
            bus.resp_valid = 1'b1;
            bus.resp_fault = fault_q;
            // Stores and faults return zero data.
            if (!fault_q && !we_q) begin
               bus.resp_rdata = load_data;
            end
         end
         default: begin
            bus.req_ready = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire
